// File: rtl/mvp_axil_reg_slave_pkg.sv
// Package for the MVP AXI4-Lite register slave: response codes, FSM state
// types and the byte-strobe merge helper shared by the top and the register bank.
package mvp_axil_pkg;

  localparam logic [1:0]  OKAY      = 2'b00;
  localparam logic [1:0]  SLVERR    = 2'b10;
  localparam int unsigned REG_BYTES = 4;

  typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_A, W_RESP} wr_state_e;
  typedef enum logic       {R_IDLE, R_RESP}                     rd_state_e;

  // Replace each byte of old_val whose strobe bit is set with the matching byte of new_val.
  function automatic logic [31:0] strb_merge(input logic [31:0]          old_val,
                                             input logic [31:0]          new_val,
                                             input logic [REG_BYTES-1:0] strb);
    logic [31:0] res;
    res = old_val;
    for (int unsigned b = 0; b < REG_BYTES; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mvp_axil_reg_slave_if.sv
// AXI4-Lite bus bundle between the platform master and the register slave.
// slave modport: address/data/valid/response-ready inputs, ready/response outputs.
// master modport: the mirror image, used by whatever drives the bus.
interface mvp_axil_reg_slave_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/mvp_axil_reg_slave_reg_bank.sv
// mvp_reg_bank: NUM_REGS x 32-bit config storage with byte-strobe merge,
// one-cycle per-register write pulses and a combinational read mux.
// Ports: clk/rst (async active-high), wr_en/wr_idx/wr_data/wr_strb commit port,
// wr_ok (write index in range), rd_idx -> rd_data/rd_ok, regs_o flat contents,
// pulse_o per-register write pulse (registered, aligned with the response).
module mvp_reg_bank
  import mvp_axil_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [31:0]              wr_data,
  input  logic [REG_BYTES-1:0]     wr_strb,
  output logic                     wr_ok,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic [31:0]              rd_data,
  output logic                     rd_ok,
  output logic [NUM_REGS*32-1:0]   regs_o,
  output logic [NUM_REGS-1:0]      pulse_o
);

  logic [NUM_REGS-1:0][31:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]       pulse_q, pulse_d;

  assign wr_ok = 32'(wr_idx) < 32'(NUM_REGS);
  assign rd_ok = 32'(rd_idx) < 32'(NUM_REGS);

  // An out-of-range index matches no entry, so it neither writes nor pulses and reads as 0.
  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (wr_en && (32'(wr_idx) == i)) begin
        regs_d[i]  = strb_merge(regs_q[i], wr_data, wr_strb);
        pulse_d[i] = 1'b1;
      end
      if (32'(rd_idx) == i) rd_data = regs_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q  <= '0;
      pulse_q <= '0;
    end else begin
      regs_q  <= regs_d;
      pulse_q <= pulse_d;
    end
  end

  assign regs_o  = regs_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/mvp_axil_reg_slave.sv
// mvp_axil_reg_slave: AXI4-Lite slave register bank feeding the SAT validation core.
// Ports: ACLK, ARESET (async active-high), s_axi (AXI4-Lite slave modport),
// cfg_regs_o (reg i at [32i+31:32i]), reg_wr_pulse_o (1-cycle pulse per written reg).
// One outstanding write and one outstanding read; the two channels are independent.
module mvp_axil_reg_slave
  import mvp_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  mvp_axil_reg_slave_if.slave            s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_regs_o,
  output logic [NUM_REGS-1:0]            reg_wr_pulse_o
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic [IDX_W-1:0]     aw_idx_q, aw_idx_d;
  logic [31:0]          w_data_q, w_data_d;
  logic [REG_BYTES-1:0] w_strb_q, w_strb_d;
  logic [1:0]           bresp_q, bresp_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [1:0]           rresp_q, rresp_d;

  logic                 awready, wready, arready, bvalid, rvalid;
  logic                 aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]     aw_bus_idx, ar_bus_idx, commit_idx;
  logic [31:0]          commit_data, rd_data;
  logic [REG_BYTES-1:0] commit_strb;
  logic                 wr_ok, rd_ok;
  logic                 unused_bits;

  assign aw_bus_idx = s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:2];
  assign ar_bus_idx = s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:2];
  assign unused_bits = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                         s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

  assign aw_hs = s_axi.S_AXI_AWVALID && awready;
  assign w_hs  = s_axi.S_AXI_WVALID  && wready;
  assign ar_hs = s_axi.S_AXI_ARVALID && arready;

  // State register (plus the latched halves of a split write and the response data).
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bresp_q    <= OKAY;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_idx_q   <= aw_idx_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bresp_q    <= bresp_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // Next state: commit fires on the edge that completes the AW/W pair.
  always_comb begin
    wr_state_d = wr_state_q;
    commit     = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_state_d = W_RESP;
          commit     = 1'b1;
        end else if (aw_hs) begin
          wr_state_d = W_WAIT_W;
        end else if (w_hs) begin
          wr_state_d = W_WAIT_A;
        end
      end
      W_WAIT_W: if (w_hs) begin
        wr_state_d = W_RESP;
        commit     = 1'b1;
      end
      W_WAIT_A: if (aw_hs) begin
        wr_state_d = W_RESP;
        commit     = 1'b1;
      end
      W_RESP: if (s_axi.S_AXI_BREADY) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase

    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      R_IDLE:  if (ar_hs) rd_state_d = R_RESP;
      R_RESP:  if (s_axi.S_AXI_RREADY) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Datapath: the half of a write arriving now comes from the bus, the other from the latch.
  always_comb begin
    aw_idx_d    = aw_hs ? aw_bus_idx : aw_idx_q;
    w_data_d    = w_hs  ? s_axi.S_AXI_WDATA : w_data_q;
    w_strb_d    = w_hs  ? s_axi.S_AXI_WSTRB : w_strb_q;
    commit_idx  = aw_idx_d;
    commit_data = w_data_d;
    commit_strb = w_strb_d;
    bresp_d     = commit ? (wr_ok ? OKAY : SLVERR) : bresp_q;
    rdata_d     = ar_hs  ? rd_data : rdata_q;
    rresp_d     = ar_hs  ? (rd_ok ? OKAY : SLVERR) : rresp_q;
  end

  // Outputs: readies are masked by ARESET so they read 0 while reset is held.
  always_comb begin
    awready = !ARESET && ((wr_state_q == W_IDLE) || (wr_state_q == W_WAIT_A));
    wready  = !ARESET && ((wr_state_q == W_IDLE) || (wr_state_q == W_WAIT_W));
    arready = !ARESET && (rd_state_q == R_IDLE);
    bvalid  = (wr_state_q == W_RESP);
    rvalid  = (rd_state_q == R_RESP);
  end

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;

  mvp_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk     (ACLK),
    .rst     (ARESET),
    .wr_en   (commit),
    .wr_idx  (commit_idx),
    .wr_data (commit_data),
    .wr_strb (commit_strb),
    .wr_ok   (wr_ok),
    .rd_idx  (ar_bus_idx),
    .rd_data (rd_data),
    .rd_ok   (rd_ok),
    .regs_o  (cfg_regs_o),
    .pulse_o (reg_wr_pulse_o)
  );

endmodule
